// File: rtl/afilt_sample_sched.sv
// ---------------------------------------------------------------------------
// afilt_sample_sched
//
// Sample scheduler for the adaptive filter datapath. Incoming audio samples
// are buffered in a small FIFO; while a frame runs, one sample is issued every
// SAMPLE_PERIOD cycles as a paired filter_en/desired_en strobe. The filter
// result is captured FILT_LAT cycles after each strobe and framed with
// out_vsync (whole frame) and out_href (one cycle per result).
//
// Ports:
//   clk_in1       system clock
//   rst_n         synchronous, active-low reset
//   start         one-cycle pulse, begins a frame when idle
//   abort         one-cycle pulse, terminates the frame and flushes the FIFO
//   in_data       input sample (feeds both filter_in and desired_in)
//   in_valid      in_data valid
//   in_ready      FIFO not full
//   filter_in     sample presented to the filter (held between issues)
//   desired_in    desired sample, always equal to filter_in
//   filter_en     one-cycle issue strobe
//   desired_en    identical to filter_en
//   filter_out    filter result
//   out_data      captured result
//   out_href      out_data valid, one cycle per result
//   out_vsync     high for the duration of a frame
//   busy          scheduler is not idle
//   underrun_cnt  saturating count of ticks that found the FIFO empty
//
// Optional feature (macro AFS_UNDERRUN_HOLD_EN):
//   When defined, a tick that finds the FIFO empty re-issues the last issued
//   sample of the frame (or 0 if none yet), so every tick produces a result.
//   When undefined, such a tick is skipped.
// ---------------------------------------------------------------------------
module afilt_sample_sched #(
  parameter int DW            = 16,
  parameter int SAMPLE_PERIOD = 1088,
  parameter int FRAME_LEN     = 200000,
  parameter int FIFO_DEPTH    = 8,
  parameter int FILT_LAT      = 3
) (
  input  logic          clk_in1,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] filter_in,
  output logic [DW-1:0] desired_in,
  output logic          filter_en,
  output logic          desired_en,
  input  logic [DW-1:0] filter_out,
  output logic [DW-1:0] out_data,
  output logic          out_href,
  output logic          out_vsync,
  output logic          busy,
  output logic [15:0]   underrun_cnt
);

  localparam int              AW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]     DEPTH_L    = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0]     PER_LAST   = 16'(SAMPLE_PERIOD - 1);
  localparam logic [19:0]     FRAME_LAST = 20'(FRAME_LEN - 1);
  localparam logic [15:0]     LAT_INIT   = 16'(FILT_LAT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t state, state_nxt;

  logic signed [DW-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          fifo_cnt;
  logic                 fifo_empty;
  logic                 push;

  logic [15:0]          per_cnt;
  logic [19:0]          frame_cnt;
  logic [15:0]          lat_cnt;
  logic                 lat_act;

  logic                 tick;
  logic                 cap_p0;
  logic                 do_start, do_issue, do_pop, do_under, do_flush;
  logic signed [DW-1:0] issue_data_p0;

`ifdef AFS_UNDERRUN_HOLD_EN
  logic                 issued_any;
`endif

  assign fifo_empty = (fifo_cnt == '0);
  assign in_ready   = (fifo_cnt != DEPTH_L);
  assign push       = in_valid & in_ready;
  assign busy       = (state != S_IDLE);
  assign tick       = (state == S_RUN) && (per_cnt == PER_LAST);
  assign cap_p0     = lat_act && (lat_cnt == 16'd0);

  // Sample to issue on a tick: FIFO head, or (hold mode, FIFO empty) the
  // last issued sample of this frame, or 0 when nothing was issued yet.
`ifdef AFS_UNDERRUN_HOLD_EN
  assign issue_data_p0 = do_pop     ? fifo_mem[rd_ptr] :
                         issued_any ? $signed(filter_in) : '0;
`else
  assign issue_data_p0 = fifo_mem[rd_ptr];
`endif

  always_ff @(posedge clk_in1) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Abort dominates everything, including a tick or capture in the same cycle.
  always_comb begin
    state_nxt = state;
    do_start  = 1'b0;
    do_issue  = 1'b0;
    do_pop    = 1'b0;
    do_under  = 1'b0;
    do_flush  = 1'b0;
    if (abort) begin
      do_flush  = 1'b1;
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            do_start  = 1'b1;
            state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          if (tick) begin
            if (!fifo_empty) begin
              do_issue = 1'b1;
              do_pop   = 1'b1;
            end else begin
              do_under = 1'b1;
`ifdef AFS_UNDERRUN_HOLD_EN
              do_issue = 1'b1;
`endif
            end
            if (do_issue && (frame_cnt == FRAME_LAST)) state_nxt = S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (cap_p0) state_nxt = S_DONE;
        end
        S_DONE: begin
          state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Input FIFO. A flush discards any push arriving in the same cycle.
  always_ff @(posedge clk_in1) begin
    if (!rst_n || do_flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, do_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_in1) begin
    if (push) fifo_mem[wr_ptr] <= $signed(in_data);
  end

  // Period counter: restarts at 0 on frame start, only advances in RUN.
  always_ff @(posedge clk_in1) begin
    if (!rst_n || do_start) per_cnt <= '0;
    else if (state == S_RUN) per_cnt <= tick ? 16'd0 : per_cnt + 16'd1;
  end

  always_ff @(posedge clk_in1) begin
    if (!rst_n || do_start) frame_cnt <= '0;
    else if (do_issue)      frame_cnt <= frame_cnt + 20'd1;
  end

  // underrun_cnt survives abort; only reset or a new frame clears it.
  always_ff @(posedge clk_in1) begin
    if (!rst_n || do_start) underrun_cnt <= '0;
    else if (do_under)      underrun_cnt <= sat_inc16(underrun_cnt);
  end

`ifdef AFS_UNDERRUN_HOLD_EN
  always_ff @(posedge clk_in1) begin
    if (!rst_n || do_start) issued_any <= 1'b0;
    else if (do_issue)      issued_any <= 1'b1;
  end
`endif

  // Issue stage (p0 -> outputs): strobe and sample to the filter.
  always_ff @(posedge clk_in1) begin
    if (!rst_n) begin
      filter_en  <= 1'b0;
      desired_en <= 1'b0;
      filter_in  <= '0;
      desired_in <= '0;
    end else begin
      filter_en  <= do_issue;
      desired_en <= do_issue;
      if (do_issue) begin
        filter_in  <= issue_data_p0;
        desired_in <= issue_data_p0;
      end
    end
  end

  // Latency counter: armed with FILT_LAT alongside the strobe, so the capture
  // fires when filter_out becomes valid, FILT_LAT cycles after filter_en.
  always_ff @(posedge clk_in1) begin
    if (!rst_n || do_flush) begin
      lat_act <= 1'b0;
      lat_cnt <= '0;
    end else if (do_issue) begin
      lat_act <= 1'b1;
      lat_cnt <= LAT_INIT;
    end else if (lat_act) begin
      if (lat_cnt == 16'd0) lat_act <= 1'b0;
      else                  lat_cnt <= lat_cnt - 16'd1;
    end
  end

  // Capture stage (p0 -> outputs): result and framing.
  always_ff @(posedge clk_in1) begin
    if (!rst_n) begin
      out_href  <= 1'b0;
      out_data  <= '0;
      out_vsync <= 1'b0;
    end else begin
      out_href <= cap_p0 && !abort;
      if (cap_p0 && !abort) out_data <= filter_out;
      if (do_flush || state == S_DONE) out_vsync <= 1'b0;
      else if (do_start)               out_vsync <= 1'b1;
    end
  end

endmodule

// File: tb/tb_afilt_sample_sched.sv
module tb_afilt_sample_sched;

  logic        clk_in1 = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] filter_in;
  logic [15:0] desired_in;
  logic        filter_en;
  logic        desired_en;
  logic [15:0] filter_out;
  logic [15:0] out_data;
  logic        out_href;
  logic        out_vsync;
  logic        busy;
  logic [15:0] underrun_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk_in1 = ~clk_in1;

  afilt_sample_sched #(
    .DW(16), .SAMPLE_PERIOD(16), .FRAME_LEN(4), .FIFO_DEPTH(4), .FILT_LAT(3)
  ) dut (
    .clk_in1(clk_in1), .rst_n(rst_n), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .filter_in(filter_in), .desired_in(desired_in),
    .filter_en(filter_en), .desired_en(desired_en),
    .filter_out(filter_out), .out_data(out_data), .out_href(out_href),
    .out_vsync(out_vsync), .busy(busy), .underrun_cnt(underrun_cnt)
  );

  // Filter model: result = input + 1, valid three cycles after the strobe.
  logic [15:0] fm1 = '0, fm2 = '0;
  initial filter_out = '0;
  always @(posedge clk_in1) begin
    fm1        <= filter_in + 16'd1;
    fm2        <= fm1;
    filter_out <= fm2;
  end

  // Frame log filled by run_log.
  int          en_cyc[8];
  logic [15:0] en_val[8];
  int          href_cyc[8];
  logic [15:0] href_val[8];
  int          n_en, n_href, vs_fall, busy_fall;
  logic        desired_ok, href_in_vs;
  logic [15:0] ur15, ur16;

  task automatic step();
    @(posedge clk_in1);
    #1;
  endtask

  task automatic do_reset();
    start = 0; abort = 0; in_valid = 0; in_data = '0;
    rst_n = 0;
    step();
    step();
    rst_n = 1;
  endtask

  task automatic prefill(input logic [15:0] v0, input logic [15:0] inc, input int n);
    for (int k = 0; k < n; k++) begin
      in_valid = 1;
      in_data  = 16'(v0 + inc * 16'(k));
      step();
    end
    in_valid = 0;
  endtask

  // Pulses start, then runs maxc cycles (cycle 0 = first RUN cycle), logging
  // strobes/results. Optional periodic pushes and an abort at abort_cyc.
  task automatic run_log(input int maxc, input int push_first, input int push_n,
                         input int abort_cyc);
    n_en = 0; n_href = 0; vs_fall = -1; busy_fall = -1;
    desired_ok = 1; href_in_vs = 1; ur15 = 'x; ur16 = 'x;
    for (int i = 0; i < 8; i++) begin
      en_cyc[i] = -1; en_val[i] = 'x; href_cyc[i] = -1; href_val[i] = 'x;
    end
    start = 1;
    step();
    start = 0;
    for (int c = 0; c < maxc; c++) begin
      if (filter_en) begin
        if (n_en < 8) begin en_cyc[n_en] = c; en_val[n_en] = filter_in; end
        n_en++;
      end
      if (out_href) begin
        if (n_href < 8) begin href_cyc[n_href] = c; href_val[n_href] = out_data; end
        n_href++;
        if (!out_vsync) href_in_vs = 0;
      end
      if (desired_en !== filter_en || desired_in !== filter_in) desired_ok = 0;
      if (vs_fall < 0 && !out_vsync) vs_fall = c;
      if (busy_fall < 0 && !busy) busy_fall = c;
      if (c == 15) ur15 = underrun_cnt;
      if (c == 16) ur16 = underrun_cnt;
      if (push_n > 0 && c >= push_first && ((c - push_first) % 16) == 0 &&
          ((c - push_first) / 16) < push_n) begin
        in_valid = 1;
        in_data  = 16'(256 * ((c - push_first) / 16 + 1));
      end
      abort = (c == abort_cyc);
      step();
      in_valid = 0;
      abort    = 0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (filter_en !== 1'b0) begin failures++; $display("FAIL rst_filter_en got=%0b exp=0", filter_en); end
    checks++; if (desired_en !== 1'b0) begin failures++; $display("FAIL rst_desired_en got=%0b exp=0", desired_en); end
    checks++; if (filter_in !== 16'h0) begin failures++; $display("FAIL rst_filter_in got=%h exp=0000", filter_in); end
    checks++; if (desired_in !== 16'h0) begin failures++; $display("FAIL rst_desired_in got=%h exp=0000", desired_in); end
    checks++; if (out_data !== 16'h0) begin failures++; $display("FAIL rst_out_data got=%h exp=0000", out_data); end
    checks++; if (out_href !== 1'b0) begin failures++; $display("FAIL rst_out_href got=%0b exp=0", out_href); end
    checks++; if (out_vsync !== 1'b0) begin failures++; $display("FAIL rst_out_vsync got=%0b exp=0", out_vsync); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    checks++; if (underrun_cnt !== 16'h0) begin failures++; $display("FAIL rst_underrun got=%h exp=0000", underrun_cnt); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_prefill_frame();
    do_reset();
    prefill(16'h0010, 16'h0010, 4);
    run_log(100, 0, 0, -1);
    checks++; if (n_en !== 4) begin failures++; $display("FAIL pf_n_en got=%0d exp=4", n_en); end
    checks++; if (n_href !== 4) begin failures++; $display("FAIL pf_n_href got=%0d exp=4", n_href); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (en_cyc[i] !== 16 * (i + 1)) begin failures++; $display("FAIL pf_en_cyc%0d got=%0d exp=%0d", i, en_cyc[i], 16 * (i + 1)); end
      checks++; if (en_val[i] !== 16'(16 * (i + 1))) begin failures++; $display("FAIL pf_en_val%0d got=%h exp=%h", i, en_val[i], 16'(16 * (i + 1))); end
      checks++; if (href_cyc[i] !== 16 * (i + 1) + 4) begin failures++; $display("FAIL pf_href_cyc%0d got=%0d exp=%0d", i, href_cyc[i], 16 * (i + 1) + 4); end
      checks++; if (href_val[i] !== 16'(16 * (i + 1) + 1)) begin failures++; $display("FAIL pf_href_val%0d got=%h exp=%h", i, href_val[i], 16'(16 * (i + 1) + 1)); end
    end
    checks++; if (vs_fall !== 69) begin failures++; $display("FAIL pf_vsync_fall got=%0d exp=69", vs_fall); end
    checks++; if (busy_fall !== 69) begin failures++; $display("FAIL pf_busy_fall got=%0d exp=69", busy_fall); end
    checks++; if (desired_ok !== 1'b1) begin failures++; $display("FAIL pf_desired_pair got=%0b exp=1", desired_ok); end
    checks++; if (href_in_vs !== 1'b1) begin failures++; $display("FAIL pf_href_in_vsync got=%0b exp=1", href_in_vs); end
    checks++; if (underrun_cnt !== 16'h0) begin failures++; $display("FAIL pf_underrun got=%h exp=0000", underrun_cnt); end
  endtask

  task automatic test_fifo_full();
    int acc, nh;
    logic r17;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1;
      in_data  = 16'(16 * (k + 1));
      step();
      if (k == 2) begin
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ff_ready_after3 got=%0b exp=1", in_ready); end
      end
    end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL ff_ready_after4 got=%0b exp=0", in_ready); end
    in_data = 16'h0050;
    step(); step(); step();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL ff_ready_held got=%0b exp=0", in_ready); end
    start = 1;
    step();
    start = 0;
    acc = -1; nh = 0; r17 = 1'bx;
    for (int c = 0; c < 100; c++) begin
      if (acc < 0 && in_ready) acc = c;
      if (c == 17) r17 = in_ready;
      if (out_href) nh++;
      step();
      if (acc >= 0) in_valid = 0;
    end
    in_valid = 0;
    checks++; if (acc !== 16) begin failures++; $display("FAIL ff_accept_cyc got=%0d exp=16", acc); end
    checks++; if (r17 !== 1'b0) begin failures++; $display("FAIL ff_ready_c17 got=%0b exp=0", r17); end
    checks++; if (nh !== 4) begin failures++; $display("FAIL ff_n_href got=%0d exp=4", nh); end
  endtask

  task automatic test_underrun_skip();
    do_reset();
    run_log(100, 20, 4, -1);
    checks++; if (ur15 !== 16'd0) begin failures++; $display("FAIL ur_cnt_c15 got=%0d exp=0", ur15); end
    checks++; if (ur16 !== 16'd1) begin failures++; $display("FAIL ur_cnt_c16 got=%0d exp=1", ur16); end
    checks++; if (n_en !== 4) begin failures++; $display("FAIL ur_n_en got=%0d exp=4", n_en); end
    checks++; if (n_href !== 4) begin failures++; $display("FAIL ur_n_href got=%0d exp=4", n_href); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (en_cyc[i] !== 32 + 16 * i) begin failures++; $display("FAIL ur_en_cyc%0d got=%0d exp=%0d", i, en_cyc[i], 32 + 16 * i); end
      checks++; if (href_val[i] !== 16'(256 * (i + 1) + 1)) begin failures++; $display("FAIL ur_href_val%0d got=%h exp=%h", i, href_val[i], 16'(256 * (i + 1) + 1)); end
    end
    checks++; if (vs_fall !== 85) begin failures++; $display("FAIL ur_vsync_fall got=%0d exp=85", vs_fall); end
    checks++; if (underrun_cnt !== 16'd1) begin failures++; $display("FAIL ur_cnt_end got=%0d exp=1", underrun_cnt); end
  endtask

  task automatic test_abort();
    do_reset();
    prefill(16'h0010, 16'h0010, 4);
    run_log(80, 0, 0, 34);
    checks++; if (n_en !== 2) begin failures++; $display("FAIL ab_n_en got=%0d exp=2", n_en); end
    checks++; if (en_cyc[1] !== 32) begin failures++; $display("FAIL ab_en2_cyc got=%0d exp=32", en_cyc[1]); end
    checks++; if (n_href !== 1) begin failures++; $display("FAIL ab_n_href got=%0d exp=1", n_href); end
    checks++; if (href_val[0] !== 16'h0011) begin failures++; $display("FAIL ab_href_val got=%h exp=0011", href_val[0]); end
    checks++; if (vs_fall !== 35) begin failures++; $display("FAIL ab_vsync_fall got=%0d exp=35", vs_fall); end
    checks++; if (busy_fall !== 35) begin failures++; $display("FAIL ab_busy_fall got=%0d exp=35", busy_fall); end
    // A fresh frame must see only the new samples if the FIFO was flushed.
    prefill(16'h00A0, 16'h0010, 4);
    run_log(100, 0, 0, -1);
    checks++; if (n_href !== 4) begin failures++; $display("FAIL ab2_n_href got=%0d exp=4", n_href); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (href_val[i] !== 16'(160 + 16 * i + 1)) begin failures++; $display("FAIL ab2_href_val%0d got=%h exp=%h", i, href_val[i], 16'(160 + 16 * i + 1)); end
    end
    checks++; if (vs_fall !== 69) begin failures++; $display("FAIL ab2_vsync_fall got=%0d exp=69", vs_fall); end
  endtask

  task automatic test_reset_midframe();
    int nh;
    do_reset();
    start = 1;
    step();
    start = 0;
    repeat (20) step();
    checks++; if (underrun_cnt !== 16'd1) begin failures++; $display("FAIL rm_underrun_pre got=%0d exp=1", underrun_cnt); end
    in_valid = 1;
    in_data  = 16'h0055;
    step();
    in_valid = 0;
    repeat (11) step();
    checks++; if (filter_en !== 1'b1 || filter_in !== 16'h0055) begin failures++; $display("FAIL rm_issue got=%0b/%h exp=1/0055", filter_en, filter_in); end
    step(); step();
    rst_n = 0;
    step();
    checks++; if (underrun_cnt !== 16'd0) begin failures++; $display("FAIL rm_underrun got=%0d exp=0", underrun_cnt); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rm_in_ready got=%0b exp=1", in_ready); end
    checks++; if (out_vsync !== 1'b0) begin failures++; $display("FAIL rm_vsync got=%0b exp=0", out_vsync); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rm_busy got=%0b exp=0", busy); end
    checks++; if (filter_in !== 16'h0 || desired_in !== 16'h0) begin failures++; $display("FAIL rm_filter_in got=%h/%h exp=0000/0000", filter_in, desired_in); end
    checks++; if (out_href !== 1'b0 || out_data !== 16'h0) begin failures++; $display("FAIL rm_out got=%0b/%h exp=0/0000", out_href, out_data); end
    checks++; if (filter_en !== 1'b0 || desired_en !== 1'b0) begin failures++; $display("FAIL rm_en got=%0b/%0b exp=0/0", filter_en, desired_en); end
    rst_n = 1;
    nh = 0;
    for (int c = 0; c < 6; c++) begin
      if (out_href) nh++;
      step();
    end
    checks++; if (nh !== 0) begin failures++; $display("FAIL rm_no_href got=%0d exp=0", nh); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rm_busy_after got=%0b exp=0", busy); end
  endtask

  initial begin
    test_reset();
    test_prefill_frame();
    test_fifo_full();
    test_underrun_skip();
    test_abort();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
